// File: rtl/ysyx_041514_pipe_ctrl.sv
// ysyx_041514_pipe_ctrl: central pipeline controller.
// Turns hazard/busy requests into per-stage stall/flush buses and drives the
// PC-redirect handshake to fetch for branch mispredicts and traps.
// Bus bit map: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (0).
// Optional build macro YSYX_041514_PIPE_PERF_EN adds three performance counters.
module ysyx_041514_pipe_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_busy_i,
    input  logic            load_use_i,
    input  logic            ex_busy_i,
    input  logic            mem_busy_i,
    input  logic            bru_redirect_valid_i,
    input  logic [XLEN-1:0] bru_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            redirect_ready_i,
    output logic [5:0]      stall_valid_o,
    output logic [5:0]      flush_valid_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef YSYX_041514_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] redirect_wait_o
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BR_WAIT   = 2'd1,
        TRAP_WAIT = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [5:0]        stall_n, flush_n;
    logic              rv_n;
    logic [XLEN-1:0]   rpc_n;
    logic              accept;
    logic              handshake;

    assign handshake = redirect_valid_o && redirect_ready_i;

    // Next-state, redirect load and stall/flush arbitration
    always_comb begin
        stall_n = 6'b0;
        flush_n = 6'b0;
        state_n = state;
        rv_n    = redirect_valid_o;
        rpc_n   = redirect_pc_o;
        accept  = 1'b0;

        // Base hazard mapping, oldest stage wins
        if (mem_busy_i) begin
            stall_n = 6'b011111;
        end else if (ex_busy_i) begin
            stall_n = 6'b000111;
            flush_n = 6'b001000;
        end else if (load_use_i) begin
            stall_n = 6'b000011;
            flush_n = 6'b000100;
        end else if (if_busy_i) begin
            stall_n = 6'b000001;
            flush_n = 6'b000010;
        end

        case (state)
            IDLE: begin
                // Events are held by their sources, so deferring them under mem_busy is safe
                if (!mem_busy_i && trap_valid_i) begin
                    flush_n      = flush_n | 6'b011110;
                    stall_n[4:1] = 4'b0;
                    stall_n[0]   = 1'b1;
                    state_n      = TRAP_WAIT;
                    rv_n         = 1'b1;
                    rpc_n        = trap_pc_i;
                    accept       = 1'b1;
                end else if (!mem_busy_i && bru_redirect_valid_i) begin
                    flush_n      = flush_n | 6'b000110;
                    stall_n[2:1] = 2'b0;
                    stall_n[0]   = 1'b1;
                    state_n      = BR_WAIT;
                    rv_n         = 1'b1;
                    rpc_n        = bru_target_i;
                    accept       = 1'b1;
                end
            end
            BR_WAIT: begin
                stall_n[0] = 1'b1;
                flush_n[1] = 1'b1;
                if (handshake) begin
                    state_n = IDLE;
                    rv_n    = 1'b0;
                end
                // A trap preempts the pending branch even if fetch just took it
                if (!mem_busy_i && trap_valid_i) begin
                    flush_n      = flush_n | 6'b011110;
                    stall_n[4:1] = 4'b0;
                    state_n      = TRAP_WAIT;
                    rv_n         = 1'b1;
                    rpc_n        = trap_pc_i;
                    accept       = 1'b1;
                end
            end
            TRAP_WAIT: begin
                stall_n[0] = 1'b1;
                flush_n[1] = 1'b1;
                if (handshake) begin
                    state_n = IDLE;
                    rv_n    = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Flush beats stall; bit5 reserved; buses forced quiet during reset
    assign stall_valid_o = rst ? (stall_n & ~flush_n & 6'b011111) : 6'b0;
    assign flush_valid_o = rst ? (flush_n & 6'b011111) : 6'b0;

    // State and registered redirect request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            state            <= state_n;
            redirect_valid_o <= rv_n;
            redirect_pc_o    <= rpc_n;
        end
    end

`ifdef YSYX_041514_PIPE_PERF_EN
    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_o  <= '0;
            flush_events_o  <= '0;
            redirect_wait_o <= '0;
        end else begin
            if (stall_valid_o[0])                       stall_cycles_o  <= stall_cycles_o + 1'b1;
            if (accept)                                 flush_events_o  <= flush_events_o + 1'b1;
            if (redirect_valid_o && !redirect_ready_i)  redirect_wait_o <= redirect_wait_o + 1'b1;
        end
    end
`endif

endmodule

// File: doc/ysyx_041514_pipe_ctrl.md
Name: ysyx_041514_pipe_ctrl

Overview:
- Central pipeline controller; the producing end of the 6-bit stall/flush control buses consumed by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates hazard and busy requests into per-stage stall/flush bits.
- Owns the PC-redirect handshake to the fetch unit for branch mispredicts and traps.
- Bus bit map: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).

Parameters:
XLEN, 64, PC/target width
CNT_W, 64, width of performance counters (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
if_busy_i  in  1  fetch has no instruction ready this cycle
load_use_i  in  1  ID detects load-use hazard
ex_busy_i  in  1  multi-cycle EX op (mul/div) not finished
mem_busy_i  in  1  LSU access outstanding
bru_redirect_valid_i  in  1  EX branch mispredict; source holds it while stalled
bru_target_i  in  XLEN  correct branch target
trap_valid_i  in  1  trap/mret taken in MEM; source holds it while stalled
trap_pc_i  in  XLEN  trap vector / mepc
redirect_ready_i  in  1  IF accepts redirect
stall_valid_o  out  6  per-stage stall (hold) bits
flush_valid_o  out  6  per-stage flush (bubble) bits
redirect_valid_o  out  1  redirect request to IF
redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset (rst=0, async): state=IDLE, redirect_valid_o=0, redirect_pc_o=0. stall_valid_o and flush_valid_o are forced 6'b0 while rst=0.
- stall/flush are combinational from inputs and state, taking effect the same cycle. redirect_* outputs are registered.
- Base hazard mapping, first match wins:
  - mem_busy_i: stall=6'b011111, flush=0.
  - ex_busy_i: stall=6'b000111, flush=6'b001000.
  - load_use_i: stall=6'b000011, flush=6'b000100.
  - if_busy_i: stall=6'b000001, flush=6'b000010.
  - none: both 0.
- Event acceptance (IDLE only, only when mem_busy_i=0):
  - trap_valid_i wins over bru_redirect_valid_i.
  - Trap accept: flush |= 6'b011110. Stall bits 1..4 are cleared. Stall bit0 is set. Next state is TRAP_WAIT, with redirect_valid_o=1 and redirect_pc_o=trap_pc_i from the next cycle.
  - Branch accept: flush |= 6'b000110. Stall bits 1..2 are cleared. Stall bit0 is set. ex_busy/load_use stalls are overridden for bits 1..2. Next state is BR_WAIT, with redirect_pc_o=bru_target_i.
- A flush bit always overrides the same stall bit: stall_o = stall & ~flush.
- BR_WAIT / TRAP_WAIT:
  - Each cycle: stall bit0=1 and flush bit1=1, ORed with the base mapping (stall & ~flush still applies).
  - When redirect_valid_o && redirect_ready_i: next state IDLE, redirect_valid_o=0 next cycle.
  - Valid is held until accepted; redirect_pc_o is stable while valid.
- Trap arriving in BR_WAIT (mem_busy_i=0):
  - Preempts: flush |= 6'b011110, redirect_pc_o is reloaded with trap_pc_i, state becomes TRAP_WAIT.
  - If redirect_ready_i is high that same cycle, the branch handshake completes, the trap is still accepted, and redirect_valid_o stays 1.
- In TRAP_WAIT, bru_redirect_valid_i and trap_valid_i are ignored.
- Latency: event at cycle N gives flush at N and redirect_valid_o at N+1. Minimum redirect occupancy is 1 cycle.
- Reset mid-wait: immediate IDLE, pending redirect dropped.

Optional Feature:
- Macro: YSYX_041514_PIPE_PERF_EN.
- When defined, adds three outputs: stall_cycles_o (CNT_W), flush_events_o (CNT_W), redirect_wait_o (CNT_W).
  - stall_cycles_o: increments each cycle stall_valid_o[0]=1.
  - flush_events_o: increments once per accepted trap/branch event.
  - redirect_wait_o: increments each cycle redirect_valid_o && !redirect_ready_i.
  - All counters reset to 0 on rst=0 and wrap modulo 2^CNT_W.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- load_use_i=1 only → stall=6'b000011, flush=6'b000100. mem_busy_i=1 added → stall=6'b011111, flush=0.
- Branch with bru_target_i=64'h8000_0100 and redirect_ready_i=0 for 3 cycles:
  - Cycle N: flush=6'b000110, stall=6'b000001.
  - Next 3 cycles: redirect_valid_o=1, redirect_pc_o=64'h8000_0100, flush=6'b000010.
  - ready=1 → IDLE next cycle.
- Trap and branch in the same cycle with trap_pc_i=64'h8000_0000 → flush=6'b011110, redirect_pc_o=64'h8000_0000, state TRAP_WAIT.
- In BR_WAIT, trap_valid_i with pc=64'h8000_0004 → redirect_pc_o switches to 64'h8000_0004 next cycle, redirect_valid_o stays 1.
- trap_valid_i with mem_busy_i=1 for 2 cycles → no flush, stall=6'b011111. Accepted in the first cycle mem_busy_i=0.
- rst=0 asserted in TRAP_WAIT → redirect_valid_o=0 immediately, buses 0. With YSYX_041514_PIPE_PERF_EN, counters read 0.
